rv32i_multicycle_ctrl: RTL and testbench
========================================

Name: rv32i_multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Sequences the shared ALU, the PC, the IR and the register file across fetch, decode, execute, memory and writeback, one instruction at a time.
- Drives the 2-bit alu_op consumed by the ALU-control decoder.
- Handles a ready handshake with unified instruction/data memory, keeps a retired-instruction counter, and flags unsupported opcodes.

Parameters:
- CNT_W, 32: width of the instret counter.
- TRAP_HALT, 1: 1 = stay in TRAP until reset; 0 = return to FETCH after one TRAP cycle.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- zero  in  1  ALU zero flag, combinational, current cycle
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  load PC
- pc_src  out  1  0 = PC from ALU result; 1 = PC from alu_out register
- ir_write  out  1  load IR and old_pc
- i_or_d  out  1  memory address: 0 = PC, 1 = alu_out
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write
- alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1 reg A
- alu_src_b  out  2  00 = rs2 reg B, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 = ADD, 01 = SUB, 10 = funct-decoded
- imm_alu  out  1  I-type ALU op; datapath forces funct7[5]=0 into ALU control
- result_src  out  2  writeback select: 00 = alu_out, 01 = mem data reg, 10 = PC
- illegal  out  1  sticky unsupported-opcode flag
- instret  out  CNT_W  retired-instruction count
- state  out  4  current state, debug

Behaviour:
- Reset: when rst is high at a clock edge, state <= FETCH, instret <= 0, illegal <= 0.
  - While rst is high, every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) is forced to 0.
  - All select outputs are 0 during reset.
  - Reset mid-instruction abandons the instruction without retiring it.
- Outputs are Moore per state. Exceptions: pc_write/ir_write are gated by mem_ready, and pc_write is gated by zero in BRANCH. Any output not listed for a state is 0.
- States and outputs:
  - FETCH: mem_read=1, i_or_d=0, a=00, b=01, alu_op=00, pc_src=0. ir_write=pc_write=mem_ready. Stay while !mem_ready; else go to DECODE.
  - DECODE: a=01, b=10, alu_op=00 (branch/jump target into alu_out). Next state by opcode:
    - 0000011 or 0100011 -> MEM_ADDR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - any other opcode -> TRAP
  - MEM_ADDR: a=10, b=10, alu_op=00. Next: MEM_READ if opcode=0000011, else MEM_WRITE.
  - MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then MEM_WB.
  - MEM_WB: reg_write=1, result_src=01. Next FETCH; retire.
  - MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready; on mem_ready go to FETCH and retire.
  - EXEC_R: a=10, b=00, alu_op=10. Next ALU_WB.
  - EXEC_I: a=10, b=10, alu_op=10, imm_alu=1. Next ALU_WB.
  - ALU_WB: reg_write=1, result_src=00. Next FETCH; retire.
  - BRANCH: a=10, b=00, alu_op=01, pc_src=1, pc_write=zero. Next FETCH; retire whether taken or not.
  - JAL: pc_write=1, pc_src=1, reg_write=1, result_src=10 (PC already holds old_pc+4). Next FETCH; retire.
  - TRAP: illegal <= 1 on entry; all strobes 0. Next TRAP if TRAP_HALT=1, else FETCH. Never retires.
- Latency with mem_ready=1 on first request cycle:
  - BEQ and JAL: 3 cycles
  - R-type, I-type and SW: 4 cycles
  - LW: 5 cycles
  - Each mem_ready-low cycle in FETCH, MEM_READ or MEM_WRITE adds exactly 1 cycle.
- Handshake: request strobes stay asserted with constant i_or_d until the mem_ready cycle. A mem_ready pulse in any other state is ignored.
- instret increments by 1 on the clock edge leaving a retiring state and wraps modulo 2^CNT_W. rst has priority over increment.
- illegal clears only on rst.
- state encoding (4 bits):
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5
  - EXEC_R=6, EXEC_I=7, ALU_WB=8, BRANCH=9, JAL=10, TRAP=11
  - Unused encodings go to FETCH on the next edge.

Test Plan:
- rst high 2 cycles, then low with mem_ready=1, opcode=0110011 -> state sequence 0,1,6,8,0; reg_write=1 only in state 8 with result_src=00; instret=1 after 4 cycles.
- LW (0000011), mem_ready low for 3 cycles in MEM_READ -> mem_read=1 and i_or_d=1 held for 4 cycles; reg_write with result_src=01 in MEM_WB; total 8 cycles; instret+1.
- BEQ with zero=1, then BEQ with zero=0 -> pc_write=1 with pc_src=1 only in the first BRANCH cycle; instret increases by 2.
- opcode 0000000 with TRAP_HALT=1 -> state 11 held indefinitely, illegal=1, instret unchanged. Repeat with TRAP_HALT=0 -> one TRAP cycle, then FETCH with illegal still 1.
- rst asserted in MEM_WRITE while mem_ready=0 -> mem_write=0 in the rst cycle, state=0 next cycle, instret=0, no retire.
- CNT_W=4, 16 retired ADDI (0010011) -> instret wraps to 0; imm_alu=1 and alu_op=10 in every EXEC_I cycle.

Source files
------------

// File: rtl/rv32i_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and tracks retired instructions and illegal opcodes.
module rv32i_multicycle_ctrl #(
    parameter int CNT_W     = 32,
    parameter bit TRAP_HALT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             imm_alu,
    output logic [1:0]       result_src,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_TRAP      = 4'd11
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             illegal_q, illegal_d;
    logic             retire;

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: begin
                state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
                retire  = mem_ready;
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_WB, S_ALU_WB, S_BRANCH, S_JAL: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP:      state_d = TRAP_HALT ? S_TRAP : S_FETCH;
            default:     state_d = S_FETCH;
        endcase
        instret_d = instret_q + CNT_W'(retire);
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore decode of the current state; reset silences every strobe and select.
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_alu    = 1'b0;
        result_src = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC_R: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                end
                S_EXEC_I: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b10;
                    imm_alu   = 1'b1;
                end
                S_ALU_WB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_src    = 1'b1;
                    pc_write  = zero;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = 1'b1;
                    reg_write  = 1'b1;
                    result_src = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Scoreboard bench: three controller instances (default, TRAP_HALT=0, CNT_W=4)
// share stimulus; per-cycle expectations are queued by the driver and popped at negedge.
module tb_rv32i_multicycle_ctrl;

    localparam logic [3:0] ST_F = 4'd0, ST_D = 4'd1, ST_MA = 4'd2, ST_MR = 4'd3,
                           ST_MWB = 4'd4, ST_MW = 4'd5, ST_ER = 4'd6, ST_EI = 4'd7,
                           ST_WB = 4'd8, ST_BR = 4'd9, ST_JAL = 4'd10, ST_TRAP = 4'd11;
    localparam logic [6:0] OPC_LW = 7'b0000011, OPC_SW = 7'b0100011, OPC_R = 7'b0110011,
                           OPC_I = 7'b0010011, OPC_BEQ = 7'b1100011, OPC_JAL = 7'b1101111;

    typedef struct packed {
        logic [3:0]  st;
        logic [3:0]  nh_st;
        logic [15:0] outs;
        logic [31:0] ret;
        logic        ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, zero, mem_ready;
    logic [6:0] opcode;

    wire [15:0] om, onh, oc4;
    wire        ill_m, ill_nh, ill_c4;
    wire [31:0] ret_m, ret_nh;
    wire [3:0]  ret_c4;
    wire [3:0]  st_m, st_nh, st_c4;

    exp_t  q[$];
    int    n_vec  = 0;
    int    n_miss = 0;
    logic [31:0] exp_ret = '0;
    logic        exp_ill = 1'b0;

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(om[15]), .pc_src(om[14]), .ir_write(om[13]), .i_or_d(om[12]),
        .mem_read(om[11]), .mem_write(om[10]), .reg_write(om[9]),
        .alu_src_a(om[8:7]), .alu_src_b(om[6:5]), .alu_op(om[4:3]),
        .imm_alu(om[2]), .result_src(om[1:0]),
        .illegal(ill_m), .instret(ret_m), .state(st_m)
    );

    rv32i_multicycle_ctrl #(.TRAP_HALT(1'b0)) u_nohalt (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(onh[15]), .pc_src(onh[14]), .ir_write(onh[13]), .i_or_d(onh[12]),
        .mem_read(onh[11]), .mem_write(onh[10]), .reg_write(onh[9]),
        .alu_src_a(onh[8:7]), .alu_src_b(onh[6:5]), .alu_op(onh[4:3]),
        .imm_alu(onh[2]), .result_src(onh[1:0]),
        .illegal(ill_nh), .instret(ret_nh), .state(st_nh)
    );

    rv32i_multicycle_ctrl #(.CNT_W(4)) u_cnt4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(oc4[15]), .pc_src(oc4[14]), .ir_write(oc4[13]), .i_or_d(oc4[12]),
        .mem_read(oc4[11]), .mem_write(oc4[10]), .reg_write(oc4[9]),
        .alu_src_a(oc4[8:7]), .alu_src_b(oc4[6:5]), .alu_op(oc4[4:3]),
        .imm_alu(oc4[2]), .result_src(oc4[1:0]),
        .illegal(ill_c4), .instret(ret_c4), .state(st_c4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check("state", 32'(st_m), 32'(e.st));
            check("outs", 32'(om), 32'(e.outs));
            check("instret", ret_m, e.ret);
            check("illegal", 32'(ill_m), 32'(e.ill));
            check("c4_state", 32'(st_c4), 32'(e.st));
            check("c4_outs", 32'(oc4), 32'(e.outs));
            check("c4_instret", 32'(ret_c4), {28'd0, e.ret[3:0]});
            check("c4_illegal", 32'(ill_c4), 32'(e.ill));
            check("nh_state", 32'(st_nh), 32'(e.nh_st));
            check("nh_illegal", 32'(ill_nh), 32'(e.ill));
            check("nh_instret", ret_nh, e.ret);
            if (e.nh_st == e.st) check("nh_outs", 32'(onh), 32'(e.outs));
        end
    end

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write, a, b, alu_op, imm, result_src
    function automatic logic [15:0] ob(input logic pcw, pcs, irw, iod, mrd, mwr, rw,
                                       input logic [1:0] a, b, op, input logic imm,
                                       input logic [1:0] rs);
        return {pcw, pcs, irw, iod, mrd, mwr, rw, a, b, op, imm, rs};
    endfunction

    task automatic step(input logic r, input logic [6:0] op, input logic z, input logic mr,
                        input logic [3:0] st, input logic [3:0] nh_st, input logic [15:0] outs);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; opcode = op; zero = z; mem_ready = mr;
        e = '{st: st, nh_st: nh_st, outs: outs, ret: exp_ret, ill: exp_ill};
        q.push_back(e);
    endtask

    task automatic s(input logic [6:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [15:0] outs);
        step(1'b0, op, z, mr, st, st, outs);
    endtask

    task automatic do_rst(input int n, input logic mr, input logic [3:0] st, input logic [3:0] nh_st);
        logic [3:0] cs = st, cn = nh_st;
        for (int i = 0; i < n; i++) begin
            step(1'b1, 7'd0, rb(), mr, cs, cn, 16'h0);
            exp_ret = '0; exp_ill = 1'b0; cs = ST_F; cn = ST_F;
        end
    endtask

    task automatic fetch(input logic [6:0] op, input int waits);
        for (int i = 0; i < waits; i++)
            s(op, rb(), 1'b0, ST_F, ob(0,0,0,0,1,0,0,2'b00,2'b01,2'b00,0,2'b00));
        s(op, rb(), 1'b1, ST_F, ob(1,0,1,0,1,0,0,2'b00,2'b01,2'b00,0,2'b00));
        s(op, rb(), rb(), ST_D, ob(0,0,0,0,0,0,0,2'b01,2'b10,2'b00,0,2'b00));
    endtask

    task automatic do_alu(input logic is_imm);
        fetch(is_imm ? OPC_I : OPC_R, 0);
        if (is_imm) s(OPC_I, rb(), rb(), ST_EI, ob(0,0,0,0,0,0,0,2'b10,2'b10,2'b10,1,2'b00));
        else        s(OPC_R, rb(), rb(), ST_ER, ob(0,0,0,0,0,0,0,2'b10,2'b00,2'b10,0,2'b00));
        s(is_imm ? OPC_I : OPC_R, rb(), rb(), ST_WB, ob(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0,2'b00));
        exp_ret++;
    endtask

    task automatic do_lw(input int fw, input int rw);
        fetch(OPC_LW, fw);
        s(OPC_LW, rb(), rb(), ST_MA, ob(0,0,0,0,0,0,0,2'b10,2'b10,2'b00,0,2'b00));
        for (int i = 0; i < rw; i++)
            s(OPC_LW, rb(), 1'b0, ST_MR, ob(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,2'b00));
        s(OPC_LW, rb(), 1'b1, ST_MR, ob(0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,2'b00));
        s(OPC_LW, rb(), rb(), ST_MWB, ob(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0,2'b01));
        exp_ret++;
    endtask

    // Leaves the store pending when complete is 0 so a reset can interrupt it.
    task automatic do_sw(input int fw, input int ww, input logic complete);
        fetch(OPC_SW, fw);
        s(OPC_SW, rb(), rb(), ST_MA, ob(0,0,0,0,0,0,0,2'b10,2'b10,2'b00,0,2'b00));
        for (int i = 0; i < ww; i++)
            s(OPC_SW, rb(), 1'b0, ST_MW, ob(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,2'b00));
        if (complete) begin
            s(OPC_SW, rb(), 1'b1, ST_MW, ob(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,2'b00));
            exp_ret++;
        end
    endtask

    task automatic do_beq(input logic z);
        fetch(OPC_BEQ, 0);
        s(OPC_BEQ, z, rb(), ST_BR, ob(z,1,0,0,0,0,0,2'b10,2'b00,2'b01,0,2'b00));
        exp_ret++;
    endtask

    task automatic do_jal();
        fetch(OPC_JAL, 0);
        s(OPC_JAL, rb(), rb(), ST_JAL, ob(1,1,0,0,0,0,1,2'b00,2'b00,2'b00,0,2'b10));
        exp_ret++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
        do_rst(2, 1'b1, ST_F, ST_F);
        do_alu(1'b0);
        do_lw(0, 3);
        do_sw(2, 1, 1'b1);
        do_beq(1'b1);
        do_beq(1'b0);
        do_jal();
        do_lw(1, 0);
        do_alu(1'b1);
        // store stalled in MEM_WRITE, then reset with mem_ready still low
        do_sw(0, 1, 1'b0);
        do_rst(1, 1'b0, ST_MW, ST_MW);
        for (int i = 0; i < 16; i++) do_alu(1'b1);
        // unsupported opcode: default instance halts, TRAP_HALT=0 instance returns to FETCH
        fetch(7'b0000000, 0);
        exp_ill = 1'b1;
        s(7'b0000000, rb(), 1'b0, ST_TRAP, 16'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 7'b0000000, rb(), 1'b0, ST_TRAP, ST_F, 16'h0);
        do_rst(1, 1'b1, ST_TRAP, ST_F);
        do_alu(1'b0);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
